// File: rtl/muladd_pkg.sv
// Shared types and sizing helpers for the shift-add multiply-accumulate.
package muladd_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BPC   = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Step counter width; a single-step build still needs one bit.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH / DEF_BPC);

endpackage

// File: rtl/muladd_seq_mul_step.sv
// One partial-product step: acc + (bit ? b << shift : 0), purely combinational.
module mul_step #(
  parameter int WIDTH = 32,
  parameter int SW    = 6
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_bit,
  input  logic [SW-1:0]      i_shift,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] w_addend;

  assign w_addend = i_bit ? ({{WIDTH{1'b0}}, i_b} << i_shift) : '0;
  assign o_acc    = i_acc + w_addend;

endmodule

// File: rtl/muladd_seq.sv
// Sequential p = a*b + c; retires BPC multiplier bits per cycle through a
// chain of mul_step instances. Used to rebuild a dividend from divmod results.
module muladd_seq
  import muladd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BPC   = DEF_BPC
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int N   = WIDTH / BPC;
  localparam int CW  = cnt_width(N);
  localparam int SW  = clog2(2 * WIDTH);
  localparam int BSH = clog2(BPC);

  state_t             r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mul;
  logic [WIDTH-1:0]   r_b;
  logic [CW-1:0]      r_cnt;

  logic [BPC:0][2*WIDTH-1:0] w_chain;
  logic [SW-1:0]             w_base;

  // BPC is a power of two, so cnt*BPC is a plain shift.
  assign w_base     = SW'(r_cnt) << BSH;
  assign w_chain[0] = r_acc;

  genvar j;
  generate
    for (j = 0; j < BPC; j++) begin : g_step
      logic [SW-1:0] w_shift;
      assign w_shift = w_base + SW'(j);
      mul_step #(.WIDTH(WIDTH), .SW(SW)) u_step (
        .i_acc   (w_chain[j]),
        .i_b     (r_b),
        .i_bit   (r_mul[j]),
        .i_shift (w_shift),
        .o_acc   (w_chain[j+1])
      );
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_mul     <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mul    <= a;
            r_b      <= b;
            r_acc    <= {{WIDTH{1'b0}}, c};
            r_cnt    <= '0;
            in_ready <= 1'b0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_chain[BPC];
          r_mul <= r_mul >> BPC;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            p         <= w_chain[BPC];
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          // Result held until the consumer takes it; inputs are ignored here.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muladd_seq.sv
// Directed and random checks of muladd_seq at BPC=1 (u1) and BPC=4 (u4).
module tb_muladd_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  iv    = '0;
  logic [1:0]  ordy  = '0;
  logic [31:0] a = '0, b = '0, c = '0;
  logic        ir1, ir4, ov1, ov4;
  logic [63:0] p1, p4;
  int          total = 0;
  int          bad   = 0;

  always #5 clock = ~clock;

  muladd_seq #(.WIDTH(32), .BPC(1)) u1 (
    .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir1),
    .a(a), .b(b), .c(c), .out_valid(ov1), .out_ready(ordy[0]), .p(p1));

  muladd_seq #(.WIDTH(32), .BPC(4)) u4 (
    .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir4),
    .a(a), .b(b), .c(c), .out_valid(ov4), .out_ready(ordy[1]), .p(p4));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int s);
    return s ? ir4 : ir1;
  endfunction
  function automatic logic vld(input int s);
    return s ? ov4 : ov1;
  endfunction
  function automatic logic [63:0] res(input int s);
    return s ? p4 : p1;
  endfunction

  // Handshake on one edge; returns with in_valid dropped, #1 after that edge.
  task automatic start(input int s, input logic [31:0] a_, b_, c_);
    int n;
    @(negedge clock);
    a = a_; b = b_; c = c_; iv[s] = 1'b1;
    n = 0;
    while (!rdy(s) && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) chk("in_ready_timeout", 64'(rdy(s)), 64'd1);
    @(posedge clock); #1;
    iv[s] = 1'b0;
  endtask

  task automatic wait_valid(input int s, output int lat);
    lat = 0;
    while (!vld(s) && lat < 200) begin @(posedge clock); #1; lat++; end
  endtask

  task automatic drain(input int s);
    ordy[s] = 1'b1;
    @(posedge clock); #1;
    ordy[s] = 1'b0;
  endtask

  task automatic op(input string tag, input int s, input logic [31:0] a_, b_, c_,
                    input logic [63:0] exp, input int exp_lat);
    int lat;
    start(s, a_, b_, c_);
    wait_valid(s, lat);
    chk(tag, res(s), exp);
    if (exp_lat > 0) chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    drain(s);
  endtask

  initial begin
    logic [63:0] held;
    int lat;
    logic [31:0] ra, rb, rc;

    #12; reset = 1'b0;
    chk("rst_in_ready", 64'(ir1), 64'd1);
    chk("rst_out_valid", 64'(ov1), 64'd0);
    chk("rst_p", p1, 64'd0);

    // Out_ready with nothing pending must not disturb the idle block.
    ordy[0] = 1'b1;
    @(posedge clock); #1;
    ordy[0] = 1'b0;
    chk("idle_ordy_ready", 64'(ir1), 64'd1);
    chk("idle_ordy_valid", 64'(ov1), 64'd0);

    for (int s = 0; s < 2; s++) begin
      op("basic", s, 32'd3, 32'd7, 32'd2, 64'h17, s ? 8 : 32);
      op("max", s, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_00000000, 0);
      op("rtrip", s, 32'd14, 32'd7, 32'd2, 64'h64, 0);
      op("zero_a", s, 32'd0, 32'h46474552, 32'd5, 64'd5, 0);
    end

    // Back-pressure: result and handshake outputs frozen while out_ready is low.
    start(0, 32'h00010000, 32'h00010000, 32'd0);
    wait_valid(0, lat);
    chk("bp_p", p1, 64'h1_00000000);
    held = p1;
    a = 32'hDEADBEEF; iv[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("bp_hold", {p1[61:0], ov1, ir1}, {held[61:0], 1'b1, 1'b0});
    end
    iv[0] = 1'b0;
    drain(0);
    chk("bp_release_ready", 64'(ir1), 64'd1);
    chk("bp_release_valid", 64'(ov1), 64'd0);
    chk("bp_p_after", p1, 64'h1_00000000);

    // Reset asserted between edges in the tenth RUN cycle.
    start(0, 32'd1234, 32'd5678, 32'd9);
    repeat (9) @(posedge clock);
    #3; reset = 1'b1; #1;
    chk("midrst_valid", 64'(ov1), 64'd0);
    chk("midrst_p", p1, 64'd0);
    chk("midrst_ready", 64'(ir1), 64'd1);
    @(negedge clock); reset = 1'b0;
    op("after_rst", 0, 32'd5, 32'd5, 32'd0, 64'd25, 32);

    // Random sweep on the 4-bit-per-cycle build against a*b+c.
    for (int i = 0; i < 2000; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
      if (i % 7 == 0) ra = '1;
      if (i % 11 == 0) rb = 32'h1 << (i % 32);
      op("rand", 1, ra, rb, rc, 64'(ra) * 64'(rb) + 64'(rc), 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
